// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // funct3 load/store size codes; 3, 6 and 7 are not members and are illegal
  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } mem_size_e;

  // MMIO register offsets within the 16-byte window
  localparam logic [3:0] OFF_TIME_LO = 4'h0;
  localparam logic [3:0] OFF_TIME_HI = 4'h4;
  localparam logic [3:0] OFF_GPIO    = 4'h8;
  localparam logic [3:0] OFF_FAULT   = 4'hC;

  // Fault codes recorded in FAULT_STAT[1:0]
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_UNMAPPED = 2'd2;
  localparam logic [1:0] FC_BOTH     = 2'd3;

  // Byte enables from size (funct3[1:0]) and the byte offset in the word
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    byte_en = 4'b0001 << off;
      2'd1:    byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_ram.sv
// Word RAM with per-byte write enables and asynchronous read.
module dmem_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane writes on the rising edge; contents are never reset
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressable RAM plus timer/GPIO/fault MMIO.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [2:0]  mem_type,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  output logic [31:0] mem_rd_data,
  output logic [31:0] gpio_out,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [63:0] r_timer;
  logic [31:0] r_time_hi_shadow;
  logic [31:0] r_gpio;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [1:0]  r_fault_code;

  logic [1:0]  w_sz;
  logic [3:0]  w_off;
  logic        w_type_ok;
  logic        w_aligned;
  logic        w_in_ram;
  logic        w_in_mmio;
  logic        w_mmio_ok;
  logic [1:0]  w_code;
  logic        w_legal;
  logic        w_ram_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_ram_shift;
  logic [31:0] w_ram_load;
  logic [31:0] w_mmio_load;
  logic        w_mmio_rd;
  logic        w_mmio_wr;
  logic        w_fault_clr;

  assign w_sz      = mem_type[1:0];
  assign w_off     = mem_addr[3:0];
  assign w_in_ram  = (mem_addr[31:AW+2] == '0);
  assign w_in_mmio = (mem_addr[31:4] == MMIO_BASE[31:4]);

  // Legality decode; the first failing rule in priority order names the fault
  always_comb begin
    w_type_ok = 1'b0;
    case (mem_type)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: w_type_ok = 1'b1;
      default:                        w_type_ok = 1'b0;
    endcase
    w_aligned = 1'b1;
    if (w_sz == 2'd1)      w_aligned = ~mem_addr[0];
    else if (w_sz == 2'd2) w_aligned = (mem_addr[1:0] == 2'b00);
    w_mmio_ok = w_in_mmio && (w_sz == 2'd2) &&
                !(mem_wr_en && (w_off == OFF_TIME_LO || w_off == OFF_TIME_HI));
    w_code = FC_NONE;
    if (mem_rd_en || mem_wr_en) begin
      if (mem_rd_en && mem_wr_en)       w_code = FC_BOTH;
      else if (!w_type_ok)              w_code = FC_UNMAPPED;
      else if (!w_aligned)              w_code = FC_MISALIGN;
      else if (!(w_in_ram || w_mmio_ok)) w_code = FC_UNMAPPED;
    end
    w_legal = (mem_rd_en || mem_wr_en) && (w_code == FC_NONE);
  end

  // Store lane steering; gating with rst drops a store caught by reset
  always_comb begin
    w_ram_we = w_legal && mem_wr_en && w_in_ram && rst;
    w_be     = byte_en(w_sz, mem_addr[1:0]) & {4{w_ram_we}};
    case (w_sz)
      2'd0:    w_wdata = {4{mem_wr_data[7:0]}};
      2'd1:    w_wdata = {2{mem_wr_data[15:0]}};
      default: w_wdata = mem_wr_data;
    endcase
  end

  dmem_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .i_clk  (CLK),
    .i_we   (w_be),
    .i_addr (mem_addr[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_rdata)
  );

  // Combinational load path: lane shift, zero-extend, MMIO mux
  always_comb begin
    w_ram_shift = w_ram_rdata >> {mem_addr[1:0], 3'b000};
    case (w_sz)
      2'd0:    w_ram_load = {24'h0, w_ram_shift[7:0]};
      2'd1:    w_ram_load = {16'h0, w_ram_shift[15:0]};
      default: w_ram_load = w_ram_shift;
    endcase
    case (w_off)
      OFF_TIME_LO: w_mmio_load = r_timer[31:0];
      OFF_TIME_HI: w_mmio_load = r_time_hi_shadow;
      OFF_GPIO:    w_mmio_load = r_gpio;
      OFF_FAULT:   w_mmio_load = {r_fault_addr[31:2], r_fault_code};
      default:     w_mmio_load = '0;
    endcase
    mem_rd_data = '0;
    if (w_legal && mem_rd_en) mem_rd_data = w_in_ram ? w_ram_load : w_mmio_load;
  end

  assign w_mmio_rd   = w_legal && mem_rd_en && w_in_mmio;
  assign w_mmio_wr   = w_legal && mem_wr_en && w_in_mmio;
  assign w_fault_clr = w_mmio_wr && (w_off == OFF_FAULT);

  // Free-running 64-bit cycle timer
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) r_timer <= '0;
    else      r_timer <= r_timer + 64'd1;
  end

  // MMIO registers and sticky first-fault capture
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_time_hi_shadow <= '0;
      r_gpio           <= '0;
      r_fault          <= 1'b0;
      r_fault_addr     <= '0;
      r_fault_code     <= FC_NONE;
    end else begin
      if (w_mmio_wr && w_off == OFF_GPIO)    r_gpio <= mem_wr_data;
      if (w_mmio_rd && w_off == OFF_TIME_LO) r_time_hi_shadow <= r_timer[63:32];
      if (w_fault_clr) begin
        r_fault      <= 1'b0;
        r_fault_addr <= '0;
        r_fault_code <= FC_NONE;
      end else if (w_code != FC_NONE && !r_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= mem_addr;
        r_fault_code <= w_code;
      end
    end
  end

  assign gpio_out = r_gpio;
  assign fault    = r_fault;

endmodule
